butterfly_unit: RTL and testbench

BUTTERFLY_UNIT -- requirements
Module: butterfly_unit

---
 rtl/fft_pkg.sv | 47 ++++
 rtl/twiddle_rom.sv | 27 ++
 rtl/butterfly_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_butterfly_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, Q2.14 twiddle format and twiddle generators
package fft_pkg;

   localparam int TW_WIDTH = 16;
   localparam int TW_FRAC  = 14;
   localparam int PIPE_LAT = 3;

   // Q2.14: 2 integer bits (sign included), 14 fraction bits; 1.0 == 16384
   typedef logic signed [TW_WIDTH-1:0] q2_14_t;

   localparam real TW_PI = 3.14159265358979323846;

   function automatic int tw_round(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   // Taylor series keeps table generation free of tool-specific math builtins
   function automatic int tw_cos_q(input int m, input int n);
      real x;
      real term;
      real sum;
      x    = 2.0 * TW_PI * real'(m) / real'(n);
      term = 1.0;
      sum  = 1.0;
      for (int i = 1; i < 16; i++) begin
         term = -term * x * x / real'((2 * i - 1) * (2 * i));
         sum  = sum + term;
      end
      return tw_round(sum * real'(1 << TW_FRAC));
   endfunction

   function automatic int tw_nsin_q(input int m, input int n);
      real x;
      real term;
      real sum;
      x    = 2.0 * TW_PI * real'(m) / real'(n);
      term = x;
      sum  = x;
      for (int i = 1; i < 16; i++) begin
         term = -term * x * x / real'((2 * i) * (2 * i + 1));
         sum  = sum + term;
      end
      return tw_round(-sum * real'(1 << TW_FRAC));
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - combinational W(m) = cos(2*pi*m/N) - j*sin(2*pi*m/N) in Q2.14
module twiddle_rom #(
   parameter int N        = 16,
   parameter int SIZE     = 4,
   parameter int TW_WIDTH = 16
) (
   input  logic        [SIZE-2:0]     m,
   output logic signed [TW_WIDTH-1:0] wr,
   output logic signed [TW_WIDTH-1:0] wi
);
   import fft_pkg::*;

   logic signed [TW_WIDTH-1:0] cos_tab  [N/2];
   logic signed [TW_WIDTH-1:0] nsin_tab [N/2];

   // Table entries are elaboration-time constants; only the index mux is real logic
   for (genvar g = 0; g < N / 2; g++) begin : g_tab
      localparam logic signed [TW_WIDTH-1:0] COS_Q  = TW_WIDTH'(tw_cos_q(g, N));
      localparam logic signed [TW_WIDTH-1:0] NSIN_Q = TW_WIDTH'(tw_nsin_q(g, N));
      assign cos_tab[g]  = COS_Q;
      assign nsin_tab[g] = NSIN_Q;
   end

   assign wr = cos_tab[m];
   assign wi = nsin_tab[m];

endmodule

// File: rtl/butterfly_unit.sv
// rtl/butterfly_unit.sv - radix-2 DIT butterfly with pair/stage counters, address
// generation and a fixed 3-stage pipeline (en_add at t -> en_wr at t+3)
module butterfly_unit #(
   parameter int bit_width = 29,
   parameter int N         = 16,
   parameter int SIZE      = 4,
   parameter int TW_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        en_add,
   input  logic signed [bit_width-1:0] Re_o1,
   input  logic signed [bit_width-1:0] Im_o1,
   input  logic signed [bit_width-1:0] Re_o2,
   input  logic signed [bit_width-1:0] Im_o2,
   output logic                        en_wr,
   output logic        [SIZE-1:0]      wr_ptr1,
   output logic        [SIZE-1:0]      wr_ptr2,
   output logic signed [bit_width-1:0] Re_i1,
   output logic signed [bit_width-1:0] Im_i1,
   output logic signed [bit_width-1:0] Re_i2,
   output logic signed [bit_width-1:0] Im_i2,
   output logic                        stage_done,
   output logic                        fft_done,
   output logic                        proto_err
);
   import fft_pkg::*;

   localparam int KW = SIZE - 1;
   localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int PW = bit_width + TW_WIDTH;
   localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SIZE - 1);

   typedef logic signed [bit_width-1:0] data_t;
   typedef logic signed [PW-1:0]        prod_t;
   typedef logic signed [TW_WIDTH-1:0]  tw_t;
   typedef logic        [SIZE-1:0]      addr_t;

   // counters
   logic [KW-1:0] k_q, k_d, eff_k;
   logic [SW-1:0] s_q, s_d, eff_s;
   logic [KW-1:0] m;
   addr_t         d_in;
   tw_t           rom_wr, rom_wi;

   // P1
   logic          v1_q, v1_d;
   data_t         ar1_q, ar1_d, ai1_q, ai1_d, br1_q, br1_d, bi1_q, bi1_d;
   tw_t           wr1_q, wr1_d, wi1_q, wi1_d;
   logic [KW-1:0] k1_q, k1_d;
   logic [SW-1:0] s1_q, s1_d;

   // P2
   logic          v2_q, v2_d;
   data_t         ar2_q, ar2_d, ai2_q, ai2_d;
   prod_t         prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
   logic [KW-1:0] k2_q, k2_d;
   logic [SW-1:0] s2_q, s2_d;

   // P3 / outputs
   logic          en_wr_q, en_wr_d;
   addr_t         ptr1_q, ptr1_d, ptr2_q, ptr2_d;
   data_t         x1r_q, x1r_d, x1i_q, x1i_d, x2r_q, x2r_d, x2i_q, x2i_d;
   logic          sd_q, sd_d, fd_q, fd_d;
   logic          perr_q, perr_d;

   logic signed [PW:0] sum_re, sum_im;
   data_t              wb_re, wb_im;
   addr_t              k_ext, d_out, top;

   // start overrides the live counters so a coincident pair is taken as k=0, s=0
   always_comb begin
      eff_k = start ? '0 : k_q;
      eff_s = start ? '0 : s_q;
      k_d   = eff_k;
      s_d   = eff_s;
      if (en_add) begin
         k_d = eff_k + KW'(1);
         if (eff_k == K_LAST) begin
            s_d = (eff_s == S_LAST) ? '0 : eff_s + SW'(1);
         end
      end
      d_in = addr_t'(1) << eff_s;
      m    = KW'((addr_t'(eff_k) & (d_in - addr_t'(1))) << (S_LAST - eff_s));
   end

   twiddle_rom #(
      .N        (N),
      .SIZE     (SIZE),
      .TW_WIDTH (TW_WIDTH)
   ) u_twiddle_rom (
      .m  (m),
      .wr (rom_wr),
      .wi (rom_wi)
   );

   always_comb begin
      v1_d  = en_add;
      ar1_d = Re_o1;
      ai1_d = Im_o1;
      br1_d = Re_o2;
      bi1_d = Im_o2;
      wr1_d = rom_wr;
      wi1_d = rom_wi;
      k1_d  = eff_k;
      s1_d  = eff_s;

      v2_d  = v1_q;
      ar2_d = ar1_q;
      ai2_d = ai1_q;
      k2_d  = k1_q;
      s2_d  = s1_q;
      prr_d = prod_t'(br1_q) * prod_t'(wr1_q);
      pii_d = prod_t'(bi1_q) * prod_t'(wi1_q);
      pri_d = prod_t'(br1_q) * prod_t'(wi1_q);
      pir_d = prod_t'(bi1_q) * prod_t'(wr1_q);

      // floor shift back to data scale, then wrap at bit_width
      sum_re = (PW + 1)'(prr_q) - (PW + 1)'(pii_q);
      sum_im = (PW + 1)'(pri_q) + (PW + 1)'(pir_q);
      wb_re  = data_t'(sum_re >>> TW_FRAC);
      wb_im  = data_t'(sum_im >>> TW_FRAC);

      k_ext = addr_t'(k2_q);
      d_out = addr_t'(1) << s2_q;
      top   = (((k_ext >> s2_q) << s2_q) << 1) | (k_ext & (d_out - addr_t'(1)));

      // data and addresses hold between results so x2 can be written a cycle later
      ptr1_d = ptr1_q;
      ptr2_d = ptr2_q;
      x1r_d  = x1r_q;
      x1i_d  = x1i_q;
      x2r_d  = x2r_q;
      x2i_d  = x2i_q;
      if (v2_q) begin
         ptr1_d = top;
         ptr2_d = top + d_out;
         x1r_d  = ar2_q + wb_re;
         x1i_d  = ai2_q + wb_im;
         x2r_d  = ar2_q - wb_re;
         x2i_d  = ai2_q - wb_im;
      end
      en_wr_d = v2_q;
      sd_d    = v2_q && (k2_q == K_LAST);
      fd_d    = v2_q && (k2_q == K_LAST) && (s2_q == S_LAST);
      perr_d  = perr_q | (en_add & v1_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q     <= '0;
         s_q     <= '0;
         v1_q    <= 1'b0;
         ar1_q   <= '0;
         ai1_q   <= '0;
         br1_q   <= '0;
         bi1_q   <= '0;
         wr1_q   <= '0;
         wi1_q   <= '0;
         k1_q    <= '0;
         s1_q    <= '0;
         v2_q    <= 1'b0;
         ar2_q   <= '0;
         ai2_q   <= '0;
         prr_q   <= '0;
         pii_q   <= '0;
         pri_q   <= '0;
         pir_q   <= '0;
         k2_q    <= '0;
         s2_q    <= '0;
         en_wr_q <= 1'b0;
         ptr1_q  <= '0;
         ptr2_q  <= '0;
         x1r_q   <= '0;
         x1i_q   <= '0;
         x2r_q   <= '0;
         x2i_q   <= '0;
         sd_q    <= 1'b0;
         fd_q    <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         k_q     <= k_d;
         s_q     <= s_d;
         v1_q    <= v1_d;
         ar1_q   <= ar1_d;
         ai1_q   <= ai1_d;
         br1_q   <= br1_d;
         bi1_q   <= bi1_d;
         wr1_q   <= wr1_d;
         wi1_q   <= wi1_d;
         k1_q    <= k1_d;
         s1_q    <= s1_d;
         v2_q    <= v2_d;
         ar2_q   <= ar2_d;
         ai2_q   <= ai2_d;
         prr_q   <= prr_d;
         pii_q   <= pii_d;
         pri_q   <= pri_d;
         pir_q   <= pir_d;
         k2_q    <= k2_d;
         s2_q    <= s2_d;
         en_wr_q <= en_wr_d;
         ptr1_q  <= ptr1_d;
         ptr2_q  <= ptr2_d;
         x1r_q   <= x1r_d;
         x1i_q   <= x1i_d;
         x2r_q   <= x2r_d;
         x2i_q   <= x2i_d;
         sd_q    <= sd_d;
         fd_q    <= fd_d;
         perr_q  <= perr_d;
      end
   end

   assign en_wr      = en_wr_q;
   assign wr_ptr1    = ptr1_q;
   assign wr_ptr2    = ptr2_q;
   assign Re_i1      = x1r_q;
   assign Im_i1      = x1i_q;
   assign Re_i2      = x2r_q;
   assign Im_i2      = x2i_q;
   assign stage_done = sd_q;
   assign fft_done   = fd_q;
   assign proto_err  = perr_q;

endmodule

// File: tb/tb_butterfly_unit.sv
// tb/tb_butterfly_unit.sv - directed vectors and corner sequences for butterfly_unit
module tb_butterfly_unit;
   localparam int BW = 29;

   logic                 clk    = 1'b0;
   logic                 rst_n  = 1'b0;
   logic                 start  = 1'b0;
   logic                 en_add = 1'b0;
   logic signed [BW-1:0] Re_o1  = '0;
   logic signed [BW-1:0] Im_o1  = '0;
   logic signed [BW-1:0] Re_o2  = '0;
   logic signed [BW-1:0] Im_o2  = '0;
   logic                 en_wr;
   logic [3:0]           wr_ptr1, wr_ptr2;
   logic signed [BW-1:0] Re_i1, Im_i1, Re_i2, Im_i2;
   logic                 stage_done, fft_done, proto_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   butterfly_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .en_add     (en_add),
      .Re_o1      (Re_o1),
      .Im_o1      (Im_o1),
      .Re_o2      (Re_o2),
      .Im_o2      (Im_o2),
      .en_wr      (en_wr),
      .wr_ptr1    (wr_ptr1),
      .wr_ptr2    (wr_ptr2),
      .Re_i1      (Re_i1),
      .Im_i1      (Im_i1),
      .Re_i2      (Re_i2),
      .Im_i2      (Im_i2),
      .stage_done (stage_done),
      .fft_done   (fft_done),
      .proto_err  (proto_err)
   );

   typedef struct {
      int pre;
      int ar, ai, br, bi;
      int p1, p2;
      int x1r, x1i, x2r, x2i;
      int sd, fd;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic issue(input logic st, input int ar, input int ai, input int br, input int bi);
      start  = st;
      en_add = 1'b1;
      Re_o1  = BW'(ar);
      Im_o1  = BW'(ai);
      Re_o2  = BW'(br);
      Im_o2  = BW'(bi);
      @(negedge clk);
      start  = 1'b0;
      en_add = 1'b0;
   endtask

   task automatic check_res(input string nm, input int p1, input int p2,
                            input int x1r, input int x1i, input int x2r, input int x2i);
      check({nm, " en_wr"}, longint'(en_wr), 1);
      check({nm, " ptr1"}, longint'(wr_ptr1), p1);
      check({nm, " ptr2"}, longint'(wr_ptr2), p2);
      check({nm, " x1r"}, longint'(Re_i1), x1r);
      check({nm, " x1i"}, longint'(Im_i1), x1i);
      check({nm, " x2r"}, longint'(Re_i2), x2r);
      check({nm, " x2i"}, longint'(Im_i2), x2i);
   endtask

   function automatic int exp_top(input int p);
      int s = p / 8;
      int k = p % 8;
      int d = 1 << s;
      return (k >> s) * 2 * d + (k & (d - 1));
   endfunction

   logic mon_on  = 1'b0;
   int   mon_cnt = 0;
   int   sd_cnt  = 0;
   int   fd_cnt  = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (en_wr) begin
            check($sformatf("frame p%0d ptr1", mon_cnt), longint'(wr_ptr1), exp_top(mon_cnt));
            check($sformatf("frame p%0d ptr2", mon_cnt), longint'(wr_ptr2),
                  exp_top(mon_cnt) + (1 << (mon_cnt / 8)));
            check($sformatf("frame p%0d stage_done", mon_cnt), longint'(stage_done),
                  longint'(mon_cnt % 8 == 7));
            check($sformatf("frame p%0d fft_done", mon_cnt), longint'(fft_done),
                  longint'(mon_cnt == 31));
            mon_cnt++;
         end
         if (stage_done) sd_cnt++;
         if (fft_done) fd_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int wr_seen;
      // pre, a, b, ptrs, x1, x2, stage_done, fft_done
      vecs[0] = '{0,  100, 50, 20, -10,      0, 1,  120, 40, 80, 60,  0, 0};
      vecs[1] = '{28, 100, 50, 20, -10,      4, 12, 90, 30, 110, 70,  0, 0};
      vecs[2] = '{0,  268435455, 0, 1, 0,    0, 1,  -268435456, 0, 268435454, 0,  0, 0};
      vecs[3] = '{11, 0, 0, 1000, 2000,      5, 7,  2000, -1000, -2000, 1000,  0, 0};
      vecs[4] = '{21, 10, -10, 16384, 0,     9, 13, 11595, -11595, -11575, 11575,  0, 0};
      vecs[5] = '{25, 0, 0, 1, 0,            1, 9,  0, -1, 0, 1,  0, 0};
      vecs[6] = '{7,  -5, 7, -3, 4,          14, 15, -8, 11, -2, 3,  1, 0};
      vecs[7] = '{31, 0, 0, 16384, 16384,    7, 15, -8867, -21407, 8867, 21407,  1, 1};

      repeat (2) @(negedge clk);
      check("rst en_wr", longint'(en_wr), 0);
      check("rst ptr2", longint'(wr_ptr2), 0);
      check("rst Re_i1", longint'(Re_i1), 0);
      check("rst Im_i2", longint'(Im_i2), 0);
      check("rst stage_done", longint'(stage_done), 0);
      check("rst fft_done", longint'(fft_done), 0);
      check("rst proto_err", longint'(proto_err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int j = 0; j < vecs[i].pre; j++) begin
            issue(1'b0, 3, -3, 7, 1);
            @(negedge clk);
         end
         issue(1'b0, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi);
         @(negedge clk);
         check($sformatf("v%0d early en_wr", i), longint'(en_wr), 0);
         @(negedge clk);
         check_res($sformatf("v%0d", i), vecs[i].p1, vecs[i].p2,
                   vecs[i].x1r, vecs[i].x1i, vecs[i].x2r, vecs[i].x2i);
         check($sformatf("v%0d stage_done", i), longint'(stage_done), vecs[i].sd);
         check($sformatf("v%0d fft_done", i), longint'(fft_done), vecs[i].fd);
         @(negedge clk);
         check($sformatf("v%0d hold en_wr", i), longint'(en_wr), 0);
         check($sformatf("v%0d hold ptr2", i), longint'(wr_ptr2), vecs[i].p2);
         check($sformatf("v%0d hold x2r", i), longint'(Re_i2), vecs[i].x2r);
         check($sformatf("v%0d hold x2i", i), longint'(Im_i2), vecs[i].x2i);
         check($sformatf("v%0d proto_err", i), longint'(proto_err), 0);
      end

      // full frame at the maximum legal rate
      mon_on = 1'b1;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 32; p++) begin
         issue(1'b0, p, -p, 2 * p + 1, 5);
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      mon_on = 1'b0;
      check("frame pairs", mon_cnt, 32);
      check("frame stage_done count", sd_cnt, 4);
      check("frame fft_done count", fd_cnt, 1);
      check("frame proto_err", longint'(proto_err), 0);

      // start coincident with en_add mid-frame
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         issue(1'b0, 1, 1, 1, 1);
         @(negedge clk);
      end
      issue(1'b1, 100, 50, 20, -10);
      check("inflight en_wr", longint'(en_wr), 1);
      check("inflight ptr1", longint'(wr_ptr1), 4);
      check("inflight ptr2", longint'(wr_ptr2), 5);
      @(negedge clk);
      issue(1'b0, 1, 2, 3, 4);
      check_res("start+en_add", 0, 1, 120, 40, 80, 60);
      @(negedge clk);
      @(negedge clk);
      check_res("after start", 2, 3, 4, 6, -2, -2);

      // back-to-back en_add
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      en_add = 1'b1;
      Re_o1 = 1;  Im_o1 = 2;  Re_o2 = 3; Im_o2 = 4;
      @(negedge clk);
      check("b2b proto_err before", longint'(proto_err), 0);
      Re_o1 = 10; Im_o1 = 20; Re_o2 = 5; Im_o2 = 5;
      @(negedge clk);
      en_add = 1'b0;
      check("b2b proto_err set", longint'(proto_err), 1);
      @(negedge clk);
      check_res("b2b first", 0, 1, 4, 6, -2, -2);
      @(negedge clk);
      check_res("b2b second", 2, 3, 15, 25, 5, 15);
      repeat (4) @(negedge clk);
      check("b2b proto_err sticky", longint'(proto_err), 1);

      // reset with a pair in flight
      issue(1'b0, 9, 9, 9, 9);
      @(negedge clk);
      issue(1'b0, 9, 9, 9, 9);
      rst_n = 1'b0;
      #1;
      check("midrst en_wr", longint'(en_wr), 0);
      check("midrst proto_err", longint'(proto_err), 0);
      check("midrst Re_i1", longint'(Re_i1), 0);
      check("midrst ptr2", longint'(wr_ptr2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (en_wr) wr_seen++;
      end
      check("midrst discarded en_wr", wr_seen, 0);
      issue(1'b0, 100, 50, 20, -10);
      @(negedge clk);
      @(negedge clk);
      check_res("post reset", 0, 1, 120, 40, 80, 60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
